ocm_dual_port_arbiter: RTL and testbench

//  Shares one single-port on-chip RAM (32-bit, 4096 words, byte enables, 1-cycle read latency)

---
 rtl/ocm_dual_port_arbiter_if.sv | 30 +++
 rtl/ocm_dual_port_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_ocm_dual_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ocm_dual_port_arbiter_if.sv
// ocm_dual_port_arbiter_if
// Avalon-MM master/slave bundle for one requester of the shared on-chip RAM.
// The master drives the command fields; the slave (the arbiter) returns
// waitrequest and the read data with its valid strobe.

interface ocm_dual_port_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [BE_W-1:0]   byteenable;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, read, write, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/ocm_dual_port_arbiter.sv
// ocm_dual_port_arbiter
// Shares one single-port on-chip RAM (1-cycle read latency, byte enables)
// between two Avalon-MM masters: port A (CPU data) and port B (DMA/video).
// Arbitration is decided combinationally every cycle: the current owner keeps
// the RAM while it requests, unless the other port is waiting and the owner
// has used up its hold allowance; ties from idle go round-robin.
// Read data is steered back to the issuing port one cycle after its grant.
// Optional build macro: OCM_ARB_STATS_EN adds stat_clear plus four 32-bit
// grant/stall counters (stat_grants_a/b, stat_stall_a/b).

module ocm_dual_port_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   ocm_dual_port_arbiter_if.slave a,
   ocm_dual_port_arbiter_if.slave b,
   output logic [ADDR_W-1:0]      mem_address,
   output logic [DATA_W/8-1:0]    mem_byteenable,
   output logic                   mem_chipselect,
   output logic                   mem_write,
   output logic [DATA_W-1:0]      mem_writedata,
   input  logic [DATA_W-1:0]      mem_readdata
`ifdef OCM_ARB_STATS_EN
   ,
   input  logic                   stat_clear,
   output logic [31:0]            stat_grants_a,
   output logic [31:0]            stat_grants_b,
   output logic [31:0]            stat_stall_a,
   output logic [31:0]            stat_stall_b
`endif
);

   localparam int BE_W   = DATA_W / 8;
   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_A = 2'd1,
      ST_OWN_B = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic              r_rr_last_b;
   logic              w_rr_last_b_nxt;

   logic              w_req_a;
   logic              w_req_b;
   logic              w_hold_open;
   logic              w_grant_a;
   logic              w_grant_b;
   logic              w_issue_rd_a;
   logic              w_issue_rd_b;

   logic [ADDR_W-1:0] r_mem_address;
   logic [BE_W-1:0]   r_mem_byteenable;
   logic [DATA_W-1:0] r_mem_writedata;
   logic [ADDR_W-1:0] w_sel_address;
   logic [BE_W-1:0]   w_sel_byteenable;
   logic [DATA_W-1:0] w_sel_writedata;
   logic              w_sel_write;

   logic              r_rd_pend_a;
   logic              r_rd_pend_b;
   logic [DATA_W-1:0] r_rdata_a;
   logic [DATA_W-1:0] r_rdata_b;

   // Request decode: a write with read also high counts as a plain write, so
   // only a read-only request ever schedules a data return.
   always_comb begin
      w_req_a      = a.read | a.write;
      w_req_b      = b.read | b.write;
      w_hold_open  = (r_hold_cnt < HOLD_LIM);
      w_issue_rd_a = w_grant_a & a.read & ~a.write;
      w_issue_rd_b = w_grant_b & b.read & ~b.write;
   end

   // Ownership state, hold counter and round-robin memory.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_hold_cnt  <= '0;
         r_rr_last_b <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_hold_cnt  <= w_hold_nxt;
         r_rr_last_b <= w_rr_last_b_nxt;
      end
   end

   // Winner selection and next ownership. Grants are forced off while reset
   // is asserted so every waitrequest reads high and the RAM sees no access.
   always_comb begin
      w_grant_a       = 1'b0;
      w_grant_b       = 1'b0;
      w_state_nxt     = ST_IDLE;
      w_hold_nxt      = '0;
      w_rr_last_b_nxt = r_rr_last_b;

      unique case (r_state)
         ST_OWN_A: begin
            if (w_req_a && (!w_req_b || w_hold_open)) begin
               w_grant_a = 1'b1;
            end else if (w_req_b) begin
               w_grant_b = 1'b1;
            end
         end
         ST_OWN_B: begin
            if (w_req_b && (!w_req_a || w_hold_open)) begin
               w_grant_b = 1'b1;
            end else if (w_req_a) begin
               w_grant_a = 1'b1;
            end
         end
         default: begin
            if (w_req_a && w_req_b) begin
               w_grant_a = r_rr_last_b;
               w_grant_b = ~r_rr_last_b;
            end else begin
               w_grant_a = w_req_a;
               w_grant_b = w_req_b;
            end
         end
      endcase

      if (!reset_n) begin
         w_grant_a = 1'b0;
         w_grant_b = 1'b0;
      end

      if (w_grant_a) begin
         w_state_nxt     = ST_OWN_A;
         w_rr_last_b_nxt = 1'b0;
         if (r_state == ST_OWN_A) begin
            w_hold_nxt = (r_hold_cnt == HOLD_LIM) ? r_hold_cnt : r_hold_cnt + HOLD_W'(1);
         end
      end else if (w_grant_b) begin
         w_state_nxt     = ST_OWN_B;
         w_rr_last_b_nxt = 1'b1;
         if (r_state == ST_OWN_B) begin
            w_hold_nxt = (r_hold_cnt == HOLD_LIM) ? r_hold_cnt : r_hold_cnt + HOLD_W'(1);
         end
      end
   end

   // RAM command mux: winner's fields on a grant, otherwise the last issued
   // address/lanes/data are held so the RAM bus does not toggle when idle.
   always_comb begin
      w_sel_address    = r_mem_address;
      w_sel_byteenable = r_mem_byteenable;
      w_sel_writedata  = r_mem_writedata;
      w_sel_write      = 1'b0;
      if (w_grant_a) begin
         w_sel_address    = a.address;
         w_sel_byteenable = a.byteenable;
         w_sel_writedata  = a.writedata;
         w_sel_write      = a.write;
      end else if (w_grant_b) begin
         w_sel_address    = b.address;
         w_sel_byteenable = b.byteenable;
         w_sel_writedata  = b.writedata;
         w_sel_write      = b.write;
      end
   end

   // Remember the last RAM command so idle cycles can replay it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem_address    <= '0;
         r_mem_byteenable <= '0;
         r_mem_writedata  <= '0;
      end else if (w_grant_a || w_grant_b) begin
         r_mem_address    <= w_sel_address;
         r_mem_byteenable <= w_sel_byteenable;
         r_mem_writedata  <= w_sel_writedata;
      end
   end

   // Read-return tags; reset drops any read still in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_pend_a <= 1'b0;
         r_rd_pend_b <= 1'b0;
      end else begin
         r_rd_pend_a <= w_issue_rd_a;
         r_rd_pend_b <= w_issue_rd_b;
      end
   end

   // Capture returned words so each port's readdata holds its last value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rdata_a <= '0;
         r_rdata_b <= '0;
      end else begin
         if (r_rd_pend_a) begin
            r_rdata_a <= mem_readdata;
         end
         if (r_rd_pend_b) begin
            r_rdata_b <= mem_readdata;
         end
      end
   end

   assign mem_address     = w_sel_address;
   assign mem_byteenable  = w_sel_byteenable;
   assign mem_writedata   = w_sel_writedata;
   assign mem_write       = w_sel_write;
   assign mem_chipselect  = w_grant_a | w_grant_b;

   assign a.waitrequest   = ~w_grant_a;
   assign b.waitrequest   = ~w_grant_b;
   assign a.readdatavalid = r_rd_pend_a;
   assign b.readdatavalid = r_rd_pend_b;
   assign a.readdata      = r_rd_pend_a ? mem_readdata : r_rdata_a;
   assign b.readdata      = r_rd_pend_b ? mem_readdata : r_rdata_b;

`ifdef OCM_ARB_STATS_EN
   logic [31:0] r_stat_grants_a;
   logic [31:0] r_stat_grants_b;
   logic [31:0] r_stat_stall_a;
   logic [31:0] r_stat_stall_b;

   // Grant and stall counters; clear wins over any increment in that cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stat_grants_a <= '0;
         r_stat_grants_b <= '0;
         r_stat_stall_a  <= '0;
         r_stat_stall_b  <= '0;
      end else if (stat_clear) begin
         r_stat_grants_a <= '0;
         r_stat_grants_b <= '0;
         r_stat_stall_a  <= '0;
         r_stat_stall_b  <= '0;
      end else begin
         r_stat_grants_a <= r_stat_grants_a + {31'd0, w_grant_a};
         r_stat_grants_b <= r_stat_grants_b + {31'd0, w_grant_b};
         r_stat_stall_a  <= r_stat_stall_a  + {31'd0, w_req_a & ~w_grant_a};
         r_stat_stall_b  <= r_stat_stall_b  + {31'd0, w_req_b & ~w_grant_b};
      end
   end

   assign stat_grants_a = r_stat_grants_a;
   assign stat_grants_b = r_stat_grants_b;
   assign stat_stall_a  = r_stat_stall_a;
   assign stat_stall_b  = r_stat_stall_b;
`endif

endmodule

// File: tb/tb_ocm_dual_port_arbiter.sv
// tb_ocm_dual_port_arbiter
// Directed scenarios followed by a randomized run, all checked cycle by cycle
// against a behavioural model: ownership tracked as a streak of consecutive
// grants, a reference word array for RAM contents, and per-port expected
// read returns. A simple RAM model answers the DUT's mem_* bus.

module tb_ocm_dual_port_arbiter;

   localparam int ADDR_W   = 12;
   localparam int DATA_W   = 32;
   localparam int MAX_HOLD = 4;
   localparam int BE_W     = DATA_W / 8;
   localparam int DEPTH    = 1 << ADDR_W;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   ocm_dual_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) aIf ();
   ocm_dual_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bIf ();

   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [DATA_W-1:0] mem_writedata;
   logic [DATA_W-1:0] mem_readdata = '0;

`ifdef OCM_ARB_STATS_EN
   logic        statClear = 1'b0;
   logic [31:0] statGrantsA, statGrantsB, statStallA, statStallB;
   int unsigned mGrantsA, mGrantsB, mStallA, mStallB;
`endif

   ocm_dual_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .a              (aIf),
      .b              (bIf),
      .mem_address    (mem_address),
      .mem_byteenable (mem_byteenable),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_readdata   (mem_readdata)
`ifdef OCM_ARB_STATS_EN
      ,
      .stat_clear     (statClear),
      .stat_grants_a  (statGrantsA),
      .stat_grants_b  (statGrantsB),
      .stat_stall_a   (statStallA),
      .stat_stall_b   (statStallB)
`endif
   );

   // RAM attached to the DUT's memory bus: byte-lane writes, registered reads.
   logic [DATA_W-1:0] ram [0:DEPTH-1];
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) begin
            for (int i = 0; i < BE_W; i++) begin
               if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
            end
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   // Bench bookkeeping and model state.
   int checks = 0;
   int errors = 0;

   logic              aRd, aWr, bRd, bWr;
   logic [ADDR_W-1:0] aAddr, bAddr;
   logic [BE_W-1:0]   aBe, bBe;
   logic [DATA_W-1:0] aWd, bWd;

   logic [DATA_W-1:0] refMem [0:DEPTH-1];
   int                modelOwner;
   int                modelStreak;
   int                modelLastPort;
   int                lastWin;
   bit                pendA, pendB;
   logic [DATA_W-1:0] pendDataA, pendDataB, lastA, lastB;
   logic [ADDR_W-1:0] holdAddr;
   logic [BE_W-1:0]   holdBe;
   logic [DATA_W-1:0] holdWd;

   logic              obsWaitA, obsWaitB, obsRdvA, obsRdvB, obsCs, obsWr;
   logic [DATA_W-1:0] obsRdataA, obsRdataB;
   logic [BE_W-1:0]   obsBe;

   int          aLeft, bLeft, nCyc, opA, opB;
   bit          bIdleNext;
   logic [11:0] seqObs;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      modelOwner    = 0;
      modelStreak   = 0;
      modelLastPort = 2;
      pendA = 1'b0;  pendB = 1'b0;
      lastA = '0;    lastB = '0;
      holdAddr = '0; holdBe = '0; holdWd = '0;
`ifdef OCM_ARB_STATS_EN
      mGrantsA = 0; mGrantsB = 0; mStallA = 0; mStallB = 0;
`endif
   endtask

   // Who should get the RAM: 0 none, 1 port A, 2 port B.
   function automatic int pickWinner(bit reqA, bit reqB);
      if (!reqA && !reqB) return 0;
      if (reqA && !reqB)  return 1;
      if (reqB && !reqA)  return 2;
      if (modelOwner == 0) return (modelLastPort == 1) ? 2 : 1;
      if (modelStreak < MAX_HOLD) return modelOwner;
      return 3 - modelOwner;
   endfunction

   task automatic applyStimulus(
      input logic ard, input logic awr, input logic [ADDR_W-1:0] aad, input logic [BE_W-1:0] abe, input logic [DATA_W-1:0] awd,
      input logic brd, input logic bwr, input logic [ADDR_W-1:0] bad, input logic [BE_W-1:0] bbe, input logic [DATA_W-1:0] bwd);
      aRd = ard; aWr = awr; aAddr = aad; aBe = abe; aWd = awd;
      bRd = brd; bWr = bwr; bAddr = bad; bBe = bbe; bWd = bwd;
      aIf.read = aRd; aIf.write = aWr; aIf.address = aAddr; aIf.byteenable = aBe; aIf.writedata = aWd;
      bIf.read = bRd; bIf.write = bWr; bIf.address = bAddr; bIf.byteenable = bBe; bIf.writedata = bWd;
   endtask

   // Check one cycle against the model at the falling edge, then advance the
   // model and move to just after the next rising edge.
   task automatic evaluateCycle();
      int win;
      @(negedge clk);
      if (!reset_n) modelReset();

      obsWaitA = aIf.waitrequest;  obsWaitB = bIf.waitrequest;
      obsRdvA  = aIf.readdatavalid; obsRdvB = bIf.readdatavalid;
      obsRdataA = aIf.readdata;    obsRdataB = bIf.readdata;
      obsCs = mem_chipselect; obsWr = mem_write; obsBe = mem_byteenable;

      checkOutput("a_readdatavalid", obsRdvA, pendA);
      checkOutput("b_readdatavalid", obsRdvB, pendB);
      if (pendA) lastA = pendDataA;
      if (pendB) lastB = pendDataB;
      checkOutput("a_readdata", obsRdataA, lastA);
      checkOutput("b_readdata", obsRdataB, lastB);

      win = reset_n ? pickWinner(aRd | aWr, bRd | bWr) : 0;
      lastWin = win;
      if (win == 1) begin holdAddr = aAddr; holdBe = aBe; holdWd = aWd; end
      if (win == 2) begin holdAddr = bAddr; holdBe = bBe; holdWd = bWd; end

      checkOutput("a_waitrequest", obsWaitA, win != 1);
      checkOutput("b_waitrequest", obsWaitB, win != 2);
      checkOutput("mem_chipselect", obsCs, win != 0);
      checkOutput("mem_write", obsWr, (win == 1) ? aWr : (win == 2) ? bWr : 1'b0);
      checkOutput("mem_address", mem_address, holdAddr);
      checkOutput("mem_byteenable", obsBe, holdBe);
      checkOutput("mem_writedata", mem_writedata, holdWd);

      pendA = (win == 1) && aRd && !aWr;
      pendB = (win == 2) && bRd && !bWr;
      pendDataA = refMem[aAddr];
      pendDataB = refMem[bAddr];
      if (win != 0 && ((win == 1) ? aWr : bWr)) begin
         for (int i = 0; i < BE_W; i++) begin
            if (holdBe[i]) refMem[holdAddr][8*i +: 8] = holdWd[8*i +: 8];
         end
      end
`ifdef OCM_ARB_STATS_EN
      if (statClear) begin
         mGrantsA = 0; mGrantsB = 0; mStallA = 0; mStallB = 0;
      end else if (reset_n) begin
         mGrantsA += (win == 1); mGrantsB += (win == 2);
         mStallA  += ((aRd | aWr) && win != 1);
         mStallB  += ((bRd | bWr) && win != 2);
      end
`endif
      if (win != 0) begin
         if (win == modelOwner) modelStreak++;
         else modelStreak = 1;
         modelLastPort = win;
      end else begin
         modelStreak = 0;
      end
      modelOwner = win;

      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
      evaluateCycle();
   endtask

   task automatic resetCycles(input int n);
      reset_n = 1'b0;
      for (int i = 0; i < n; i++) idleCycle();
      reset_n = 1'b1;
   endtask

   // Watchdog so a stuck run still ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]    = $urandom;
         refMem[i] = ram[i];
      end
      ram[12'h010]    = 32'hDEADBEEF;
      refMem[12'h010] = 32'hDEADBEEF;
      reset_n = 1'b0;
      modelReset();
      applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
      @(posedge clk);
      #1;
      resetCycles(2);

      // Single port A read with 1-cycle return.
      applyStimulus(1, 0, 12'h010, 4'hF, '0, 0, 0, '0, '0, '0);
      evaluateCycle();
      checkOutput("t1_a_wait", obsWaitA, 1'b0);
      idleCycle();
      checkOutput("t1_a_rdv", obsRdvA, 1'b1);
      checkOutput("t1_a_rdata", obsRdataA, 32'hDEADBEEF);

      // Both ports request right after reset: A first, then B.
      resetCycles(1);
      applyStimulus(1, 0, 12'h010, 4'hF, '0, 1, 0, 12'h020, 4'hF, '0);
      evaluateCycle();
      checkOutput("t2_a_first", {obsWaitA, obsWaitB}, 2'b01);
      applyStimulus(0, 0, '0, '0, '0, 1, 0, 12'h020, 4'hF, '0);
      evaluateCycle();
      checkOutput("t2_b_second", obsWaitB, 1'b0);
      checkOutput("t2_a_rdv", obsRdvA, 1'b1);
      idleCycle();
      checkOutput("t2_b_rdv", {obsRdvA, obsRdvB}, 2'b01);

      // A streams 10 writes against B's reads: hold limit forces B in.
      resetCycles(1);
      aLeft = 10; bLeft = 2; bIdleNext = 1'b0; nCyc = 0; seqObs = '0;
      while ((aLeft > 0 || bLeft > 0) && nCyc < 30) begin
         applyStimulus(0, aLeft > 0, 12'h100 + 12'(nCyc), 4'hF, $urandom,
                       (bLeft > 0) && !bIdleNext, 0, 12'h010, 4'hF, '0);
         evaluateCycle();
         seqObs = {seqObs[10:0], ~obsWaitB};
         nCyc++;
         bIdleNext = 1'b0;
         if (lastWin == 1) aLeft--;
         if (lastWin == 2) begin bLeft--; bIdleNext = 1'b1; end
      end
      checkOutput("t3_cycles", nCyc, 12);
      checkOutput("t3_order", seqObs, 12'b000010000100);
      idleCycle();

      // Read+write counts as a write; then read back the merged word.
      applyStimulus(0, 1, 12'h030, 4'hF, 32'hAABBCCDD, 0, 0, '0, '0, '0);
      evaluateCycle();
      applyStimulus(1, 1, 12'h030, 4'b0011, 32'h11223344, 0, 0, '0, '0, '0);
      evaluateCycle();
      checkOutput("t4_mem_write", obsWr, 1'b1);
      checkOutput("t4_mem_be", obsBe, 4'b0011);
      applyStimulus(1, 0, 12'h030, 4'hF, '0, 0, 0, '0, '0, '0);
      evaluateCycle();
      checkOutput("t4_no_rdv", obsRdvA, 1'b0);
      idleCycle();
      checkOutput("t4_merged", obsRdataA, 32'hAABB3344);

      // Reset right after a B read grant discards the return.
      applyStimulus(0, 0, '0, '0, '0, 1, 0, 12'h010, 4'hF, '0);
      evaluateCycle();
      checkOutput("t5_b_grant", obsWaitB, 1'b0);
      reset_n = 1'b0;
      applyStimulus(1, 0, 12'h040, 4'hF, '0, 0, 0, '0, '0, '0);
      evaluateCycle();
      checkOutput("t5_b_rdv", obsRdvB, 1'b0);
      checkOutput("t5_a_wait", obsWaitA, 1'b1);
      checkOutput("t5_cs", obsCs, 1'b0);
      reset_n = 1'b1;
      idleCycle();
      checkOutput("t5_b_rdv_after", obsRdvB, 1'b0);

      // Randomized traffic on a small address window, with one reset.
      for (int i = 0; i < 300; i++) begin
         reset_n = (i == 150) ? 1'b0 : 1'b1;
         opA = $urandom_range(0, 5);
         opB = $urandom_range(0, 5);
         applyStimulus(opA == 2 || opA == 3 || opA == 5, opA >= 4,
                       12'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
                       opB == 2 || opB == 3 || opB == 5, opB >= 4,
                       12'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
         evaluateCycle();
      end
      reset_n = 1'b1;
      idleCycle();

`ifdef OCM_ARB_STATS_EN
      checkOutput("stat_grants_a", statGrantsA, mGrantsA);
      checkOutput("stat_grants_b", statGrantsB, mGrantsB);
      checkOutput("stat_stall_a", statStallA, mStallA);
      checkOutput("stat_stall_b", statStallB, mStallB);
      statClear = 1'b1;
      idleCycle();
      statClear = 1'b0;
      checkOutput("stat_clear", statGrantsA | statGrantsB | statStallA | statStallB, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
